// File: rtl/di_fifo_reader_pkg.sv
// Shared definitions for the di FIFO read terminal: FSM encoding, default
// register map, timeout fill word and status register layout.
package di_fifo_reader_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } rd_state_e;

  localparam logic [15:0] REG_DATA_DEF   = 16'h0000;
  localparam logic [15:0] REG_STATUS_DEF = 16'h0001;
  localparam logic [15:0] REG_CTRL_DEF   = 16'h0002;
  localparam logic [15:0] FILL_WORD_DEF  = 16'hDEAD;

  localparam int STAT_UNDERFLOW_BIT = 15;
  localparam int STAT_OVERFLOW_BIT  = 14;

  function automatic logic [15:0] build_status(input logic underflow,
                                               input logic overflow,
                                               input logic [13:0] count);
    logic [15:0] s;
    s = {2'b00, count};
    s[STAT_UNDERFLOW_BIT] = underflow;
    s[STAT_OVERFLOW_BIT]  = overflow;
    return s;
  endfunction

endpackage

// File: rtl/di_sync_fifo.sv
// Single-clock FIFO with combinational head. A push into a full FIFO is
// accepted only when a pop retires a word in the same cycle.
module di_sync_fifo #(
  parameter int DEPTH_LOG2 = 9,
  parameter int WIDTH      = 16
) (
  input  logic                  if_clock,
  input  logic                  resetb,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = count[DEPTH_LOG2];
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge if_clock) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge if_clock) begin
    if (!resetb || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/di_fifo_reader.sv
// Buffered streaming read terminal on the di bus: the host drains a producer
// FIFO through one data register, stalled by rdwr_ready while it is empty.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no read outstanding, rdwr_ready high
// ST_WAIT | data read pending; pop head or fill word after the timeout
module di_fifo_reader
  import di_fifo_reader_pkg::*;
#(
  parameter logic [15:0] EP_ADDR    = 16'h0000,
  parameter logic [15:0] REG_DATA   = REG_DATA_DEF,
  parameter logic [15:0] REG_STATUS = REG_STATUS_DEF,
  parameter logic [15:0] REG_CTRL   = REG_CTRL_DEF,
  parameter int          DEPTH_LOG2 = 9,
  parameter int          TIMEOUT    = 255,
  parameter logic [15:0] FILL_WORD  = FILL_WORD_DEF
) (
  input  logic                if_clock,
  input  logic                resetb,
  input  logic [15:0]         diEpAddr,
  input  logic [15:0]         diRegAddr,
  input  logic [15:0]         diRegDataIn,
  output logic [15:0]         diRegDataOut,
  input  logic                diWrite,
  input  logic                diRead,
  input  logic                diReset,
  output logic                rdwr_ready,
  input  logic                fifo_we,
  input  logic [15:0]         fifo_din,
  output logic                fifo_full,
  output logic [DEPTH_LOG2:0] fifo_count
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  rd_state_e   state, state_nxt;
  logic [15:0] tmo_cnt, tmo_nxt;
  logic [15:0] dout, dout_nxt;
  logic        ready_nxt;
  logic        underflow, overflow;
  logic        uf_set, ov_set;
  logic        pop, flush, clr_flags;
  logic        sel, rd_data, wr_ctrl;
  logic        fifo_empty;
  logic [15:0] fifo_head;
  logic        ctrl_unused;

  assign sel       = (diEpAddr == EP_ADDR);
  assign rd_data   = sel & diRead & (diRegAddr == REG_DATA);
  assign wr_ctrl   = sel & diWrite & (diRegAddr == REG_CTRL);
  assign flush     = diReset | (wr_ctrl & diRegDataIn[0]);
  assign clr_flags = wr_ctrl & diRegDataIn[1];
  assign ctrl_unused = ^diRegDataIn[15:2];

  // A push into a full FIFO survives only when the FSM pops in the same cycle.
  assign ov_set = fifo_we & fifo_full & ~pop & ~flush;

  di_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (16)
  ) u_fifo (
    .if_clock (if_clock),
    .resetb   (resetb),
    .push     (fifo_we),
    .pop      (pop),
    .flush    (flush),
    .din      (fifo_din),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    state_nxt = state;
    tmo_nxt   = tmo_cnt;
    dout_nxt  = dout;
    ready_nxt = rdwr_ready;
    pop       = 1'b0;
    uf_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_nxt = 1'b1;
        if (rd_data) begin
          state_nxt = ST_WAIT;
          ready_nxt = 1'b0;
          tmo_nxt   = '0;
        end
      end
      ST_WAIT: begin
        if (!fifo_empty) begin
          dout_nxt  = fifo_head;
          pop       = 1'b1;
          ready_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          dout_nxt  = FILL_WORD;
          uf_set    = 1'b1;
          ready_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          tmo_nxt = tmo_cnt + 16'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Host soft reset abandons any pending read without returning data.
    if (diReset) begin
      state_nxt = ST_IDLE;
      tmo_nxt   = '0;
      dout_nxt  = '0;
      ready_nxt = 1'b1;
      pop       = 1'b0;
      uf_set    = 1'b0;
    end
  end

  always_ff @(posedge if_clock) begin
    if (!resetb) begin
      state      <= ST_IDLE;
      tmo_cnt    <= '0;
      dout       <= '0;
      rdwr_ready <= 1'b1;
      underflow  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      tmo_cnt    <= tmo_nxt;
      dout       <= dout_nxt;
      rdwr_ready <= ready_nxt;
      if (diReset) begin
        underflow <= 1'b0;
        overflow  <= 1'b0;
      end else begin
        underflow <= (underflow & ~clr_flags) | uf_set;
        overflow  <= (overflow & ~clr_flags) | ov_set;
      end
    end
  end

  always_comb begin
    diRegDataOut = '0;
    if (sel) begin
      if (diRegAddr == REG_DATA)
        diRegDataOut = dout;
      else if (diRegAddr == REG_STATUS)
        diRegDataOut = build_status(underflow, overflow, 14'(fifo_count));
    end
  end

endmodule

// File: tb/tb_di_fifo_reader.sv
// Directed bench for di_fifo_reader with a 4-word FIFO and a 255-cycle timeout.
module tb_di_fifo_reader;

  localparam int DL2 = 2;

  logic          if_clock = 1'b0;
  logic          resetb;
  logic [15:0]   diEpAddr, diRegAddr, diRegDataIn, diRegDataOut;
  logic          diWrite, diRead, diReset, rdwr_ready;
  logic          fifo_we, fifo_full;
  logic [15:0]   fifo_din;
  logic [DL2:0]  fifo_count;

  int n_chk = 0;
  int n_bad = 0;

  always #5 if_clock = ~if_clock;

  di_fifo_reader #(
    .DEPTH_LOG2 (DL2),
    .TIMEOUT    (255)
  ) dut (
    .if_clock     (if_clock),
    .resetb       (resetb),
    .diEpAddr     (diEpAddr),
    .diRegAddr    (diRegAddr),
    .diRegDataIn  (diRegDataIn),
    .diRegDataOut (diRegDataOut),
    .diWrite      (diWrite),
    .diRead       (diRead),
    .diReset      (diReset),
    .rdwr_ready   (rdwr_ready),
    .fifo_we      (fifo_we),
    .fifo_din     (fifo_din),
    .fifo_full    (fifo_full),
    .fifo_count   (fifo_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge if_clock);
  endtask

  task automatic push(input logic [15:0] w);
    fifo_we = 1'b1; fifo_din = w;
    step();
    fifo_we = 1'b0;
  endtask

  task automatic write_ctrl(input logic [15:0] v);
    diRegAddr = 16'h0002; diRegDataIn = v; diWrite = 1'b1;
    step();
    diWrite = 1'b0;
  endtask

  task automatic read_status(output logic [15:0] s);
    diRegAddr = 16'h0001;
    #1 s = diRegDataOut;
  endtask

  // Data read; optionally pushes push_word during wait cycle push_at (1 = first).
  task automatic do_read(input logic [15:0] push_word, input int push_at,
                         output logic [15:0] data, output int low);
    diRegAddr = 16'h0000; diRead = 1'b1;
    step();
    diRead = 1'b0;
    low = 0;
    while (!rdwr_ready && low < 400) begin
      low++;
      fifo_we  = (low == push_at);
      fifo_din = push_word;
      step();
    end
    fifo_we = 1'b0;
    data = diRegDataOut;
  endtask

  logic [15:0] d, s;
  int          low;
  logic [15:0] exp_drain [4];

  initial begin
    resetb = 1'b0; diEpAddr = 16'h0000; diRegAddr = 16'h0000; diRegDataIn = 16'h0000;
    diWrite = 1'b0; diRead = 1'b0; diReset = 1'b0; fifo_we = 1'b0; fifo_din = 16'h0000;
    step(); step();
    resetb = 1'b1;
    check_val("rst_ready", 32'(rdwr_ready), 32'd1);
    check_val("rst_count", 32'(fifo_count), 32'd0);
    check_val("rst_full",  32'(fifo_full), 32'd0);
    check_val("rst_dout",  32'(diRegDataOut), 32'h0);
    read_status(s);
    check_val("rst_status", 32'(s), 32'h0);

    // In-order streaming from a pre-filled FIFO
    push(16'h0001); push(16'h0002); push(16'h0003);
    check_val("t1_count", 32'(fifo_count), 32'd3);
    for (int i = 1; i <= 3; i++) begin
      do_read(16'h0, 0, d, low);
      check_val($sformatf("t1_data%0d", i), 32'(d), 32'(i));
      check_val($sformatf("t1_low%0d", i), 32'(low), 32'd1);
    end
    read_status(s);
    check_val("t1_status", 32'(s), 32'h0);

    // Wait states until a late push
    do_read(16'hBEEF, 10, d, low);
    check_val("t2_data", 32'(d), 32'hBEEF);
    check_val("t2_low", 32'(low), 32'd11);
    read_status(s);
    check_val("t2_status", 32'(s), 32'h0);

    // Timeout returns the fill word and flags underflow
    do_read(16'h0, 0, d, low);
    check_val("t3_data", 32'(d), 32'hDEAD);
    check_val("t3_low", 32'(low), 32'd255);
    read_status(s);
    check_val("t3_status", 32'(s), 32'h8000);
    write_ctrl(16'h0002);
    check_val("t3_ctrl_ready", 32'(rdwr_ready), 32'd1);
    read_status(s);
    check_val("t3_clr", 32'(s), 32'h0);

    // Overflow on full FIFO, then push+pop while full
    push(16'h0011); push(16'h0022); push(16'h0033); push(16'h0044);
    check_val("t4_full", 32'(fifo_full), 32'd1);
    push(16'h0055);
    check_val("t4_count", 32'(fifo_count), 32'd4);
    read_status(s);
    check_val("t4_status", 32'(s), 32'h4004);

    diEpAddr = 16'h0001;
    #1 check_val("t4_unsel_out", 32'(diRegDataOut), 32'h0);
    diRegAddr = 16'h0000; diRead = 1'b1;
    step();
    diRead = 1'b0;
    check_val("t4_unsel_ready", 32'(rdwr_ready), 32'd1);
    check_val("t4_unsel_count", 32'(fifo_count), 32'd4);
    diEpAddr = 16'h0000;

    write_ctrl(16'h0002);
    do_read(16'h0066, 1, d, low);
    check_val("t4_pp_data", 32'(d), 32'h0011);
    check_val("t4_pp_count", 32'(fifo_count), 32'd4);
    read_status(s);
    check_val("t4_pp_status", 32'(s), 32'h0004);
    exp_drain[0] = 16'h0022; exp_drain[1] = 16'h0033;
    exp_drain[2] = 16'h0044; exp_drain[3] = 16'h0066;
    for (int i = 0; i < 4; i++) begin
      do_read(16'h0, 0, d, low);
      check_val($sformatf("t4_drain%0d", i), 32'(d), 32'(exp_drain[i]));
    end
    check_val("t4_empty", 32'(fifo_count), 32'd0);

    // Soft reset in the middle of a read
    push(16'h0101); push(16'h0102); push(16'h0103);
    diRegAddr = 16'h0000; diRead = 1'b1;
    step();
    diRead = 1'b0;
    check_val("t5_in_wait", 32'(rdwr_ready), 32'd0);
    diReset = 1'b1;
    step();
    diReset = 1'b0;
    check_val("t5_ready", 32'(rdwr_ready), 32'd1);
    check_val("t5_count", 32'(fifo_count), 32'd0);
    check_val("t5_full", 32'(fifo_full), 32'd0);
    check_val("t5_dout", 32'(diRegDataOut), 32'h0);
    read_status(s);
    check_val("t5_status", 32'(s), 32'h0);
    push(16'h0077);
    do_read(16'h0, 0, d, low);
    check_val("t5_idle_data", 32'(d), 32'h0077);
    check_val("t5_idle_low", 32'(low), 32'd1);

    // Flush beats a simultaneous push
    push(16'h00AA);
    check_val("t5_pre_flush", 32'(fifo_count), 32'd1);
    diRegAddr = 16'h0002; diRegDataIn = 16'h0001; diWrite = 1'b1;
    fifo_we = 1'b1; fifo_din = 16'h0099;
    step();
    diWrite = 1'b0; fifo_we = 1'b0;
    check_val("t5_flush_count", 32'(fifo_count), 32'd0);
    check_val("t5_flush_ready", 32'(rdwr_ready), 32'd1);
    read_status(s);
    check_val("t5_flush_status", 32'(s), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
